queue_calc_ctrl: RTL and testbench
==================================

QUEUE_CALC_CTRL -- requirements
Module: queue_calc_ctrl

Interface
REQ-001 Parameter DEPTH, default 8: operand-queue entries; SHALL be a power of two, at least 2; AW = log2(DEPTH).
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-003 rst  input  1  reset, synchronous and active-low: asserted when low, sampled on the rising edge of clk.
REQ-004 in_valid  input  1  instruction offered.
REQ-005 in_ready  output  1  controller accepts an instruction this cycle.
REQ-006 in_opcode  input  3  0 PUSH, 1 POP, 2 ADD, 3 MUL, 4 SUB, 5 DIV, 6 REM, 7 NOP.
REQ-007 in_data  input  8  PUSH immediate.
REQ-008 alu_opcode  output  3  opcode driven to the ALU.
REQ-009 alu_operands  output  16  [7:0] first-dequeued operand A, [15:8] second-dequeued operand B.
REQ-010 alu_result  input  8  combinational ALU result.
REQ-011 out_valid  output  1  one-cycle pulse carrying a POP value.
REQ-012 out_data  output  8  POP value, held until the next POP.
REQ-013 count  output  AW+1  current queue occupancy.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 err_valid  output  1  one-cycle error pulse.
REQ-016 err_code  output  2  01 underflow, 10 overflow, 11 divide-by-zero; held until the next error.

Function
REQ-017 Controller SHALL own a DEPTH x 8 circular queue with head/tail pointers that wrap modulo DEPTH.
REQ-018 FSM states SHALL be IDLE, READ_A, READ_B, EXEC, WRITE.
REQ-019 in_ready SHALL be 1 only in IDLE; an instruction is accepted on a cycle with in_valid && in_ready.
REQ-020 PUSH accepted: if count==DEPTH, pulse err_valid with code 10 next cycle, queue unchanged, stay IDLE; else go to WRITE and enqueue in_data, returning to IDLE. Entry visible and count incremented 2 cycles after accept.
REQ-021 POP accepted: if count==0, error 01; else next cycle dequeue head, set out_data, pulse out_valid, decrement count, stay IDLE.
REQ-022 Binary op (2-6) accepted with count<2: error 01, queue unchanged, stay IDLE.
REQ-023 Binary op with count>=2 SHALL sequence IDLE->READ_A (dequeue into A) ->READ_B (dequeue into B) ->EXEC (drive alu_opcode/alu_operands, register alu_result) ->WRITE (enqueue result) ->IDLE; in_ready reasserts 5 cycles after accept.
REQ-024 alu_opcode SHALL be 7 and alu_operands 0 outside EXEC.
REQ-025 Binary-op WRITE SHALL never overflow: two entries were freed before it.
REQ-026 NOP SHALL have no effect and keep in_ready high.
REQ-027 Result arithmetic is the ALU's, 8-bit truncated; SUB is A-B and DIV is A/B.

Reset
REQ-028 With rst low at a clock edge: state IDLE; head, tail and count 0; out_valid, err_valid and busy 0; out_data, err_code, alu_operands 0; alu_opcode 7; in_ready 0 during the reset cycle.
REQ-029 Reset mid-operation SHALL abort the sequence; all queue contents are discarded.

Configuration
REQ-030 Macro QCTRL_DIVZERO_CHK_EN: when defined, DIV/REM with B==0 SHALL, in EXEC, pulse error 11, skip WRITE and return to IDLE with both operands consumed (count reduced by 2).
REQ-031 Without QCTRL_DIVZERO_CHK_EN, DIV/REM with B==0 SHALL push the ALU result unmodified, with no error.

Verification
REQ-032 Reset, PUSH 5, PUSH 3, ADD, POP -> out_data 8, count 0, no error.
REQ-033 PUSH 3, PUSH 10, SUB, POP -> out_data 8'hF9 (3-10 wraps); ADD accept-to-in_ready latency 5 cycles.
REQ-034 DEPTH+1 PUSHes (values 1..9) -> ninth gives err_code 10; POPs return 1..8 in order, exercising wrap after refill.
REQ-035 POP on an empty queue, and MUL with count 1 -> err_code 01 each time, count unchanged.
REQ-036 PUSH 7, PUSH 0, DIV with macro defined -> err_code 11, count 0; without the macro -> no error, count 1.
REQ-037 rst low during EXEC -> next cycle IDLE, count 0, in_ready 1 after release.

Source files
------------

// File: rtl/queue_calc_ctrl.sv
// queue_calc_ctrl: stack-style calculator controller that owns a DEPTH x 8 circular operand queue.
// Latency: PUSH is 2 cycles to IDLE, POP/NOP/errors 1 cycle, binary ops 5 cycles from accept to in_ready.
// Backpressure: in_ready is high only in IDLE and outside reset; an instruction is taken on in_valid && in_ready.
//
// Optional feature macro: QCTRL_DIVZERO_CHK_EN. When it is defined, DIV/REM with B == 0
// raises error 11 in EXEC instead of writing the ALU result back.
//
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   in_valid/in_ready   instruction handshake; in_opcode (3b), in_data (8b PUSH immediate)
//   alu_opcode          opcode to the external ALU, 7 (NOP) outside EXEC
//   alu_operands        {B, A} to the ALU, 0 outside EXEC
//   alu_result          combinational ALU result
//   out_valid/out_data  POP result pulse / held value
//   count, busy         queue occupancy, non-IDLE indicator
//   err_valid/err_code  error pulse / held code (01 underflow, 10 overflow, 11 div-by-zero)
module queue_calc_ctrl #(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    in_opcode,
  input  logic [7:0]    in_data,
  output logic [2:0]    alu_opcode,
  output logic [15:0]   alu_operands,
  input  logic [7:0]    alu_result,
  output logic          out_valid,
  output logic [7:0]    out_data,
  output logic [AW:0]   count,
  output logic          busy,
  output logic          err_valid,
  output logic [1:0]    err_code
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_READ_A = 3'd1;
  localparam logic [2:0] S_READ_B = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_WRITE  = 3'd4;

  localparam logic [2:0] OP_PUSH = 3'd0;
  localparam logic [2:0] OP_POP  = 3'd1;
  localparam logic [2:0] OP_DIV  = 3'd5;
  localparam logic [2:0] OP_REM  = 3'd6;
  localparam logic [2:0] OP_NOP  = 3'd7;

  localparam logic [1:0] ERR_UNDER = 2'b01;
  localparam logic [1:0] ERR_OVER  = 2'b10;
  localparam logic [1:0] ERR_DIVZ  = 2'b11;

  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_TWO  = (AW+1)'(2);

  logic [2:0]    state;
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [2:0]    op_q;
  logic [7:0]    opa;
  logic [7:0]    opb;
  // Value enqueued in WRITE: either the PUSH immediate or the registered ALU result.
  logic [7:0]    wdat;
  logic [7:0]    mem [DEPTH];

  assign in_ready     = (state == S_IDLE) && rst;
  assign busy         = (state != S_IDLE);
  assign alu_opcode   = (state == S_EXEC) ? op_q : OP_NOP;
  assign alu_operands = (state == S_EXEC) ? {opb, opa} : 16'd0;

  // Queue storage carries no reset; pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (rst && state == S_WRITE) begin
      mem[tail] <= wdat;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      op_q      <= OP_NOP;
      opa       <= 8'd0;
      opb       <= 8'd0;
      wdat      <= 8'd0;
      out_valid <= 1'b0;
      out_data  <= 8'd0;
      err_valid <= 1'b0;
      err_code  <= 2'b00;
    end else begin
      out_valid <= 1'b0;
      err_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            case (in_opcode)
              OP_PUSH: begin
                if (count == CNT_FULL) begin
                  err_valid <= 1'b1;
                  err_code  <= ERR_OVER;
                end else begin
                  wdat  <= in_data;
                  state <= S_WRITE;
                end
              end
              OP_POP: begin
                if (count == '0) begin
                  err_valid <= 1'b1;
                  err_code  <= ERR_UNDER;
                end else begin
                  out_data  <= mem[head];
                  out_valid <= 1'b1;
                  head      <= head + 1'b1;
                  count     <= count - 1'b1;
                end
              end
              OP_NOP: ;
              default: begin
                // Binary ops need two live operands before any state is touched.
                if (count < CNT_TWO) begin
                  err_valid <= 1'b1;
                  err_code  <= ERR_UNDER;
                end else begin
                  op_q  <= in_opcode;
                  state <= S_READ_A;
                end
              end
            endcase
          end
        end
        S_READ_A: begin
          opa   <= mem[head];
          head  <= head + 1'b1;
          count <= count - 1'b1;
          state <= S_READ_B;
        end
        S_READ_B: begin
          opb   <= mem[head];
          head  <= head + 1'b1;
          count <= count - 1'b1;
          state <= S_EXEC;
        end
        S_EXEC: begin
`ifdef QCTRL_DIVZERO_CHK_EN
          if ((op_q == OP_DIV || op_q == OP_REM) && opb == 8'd0) begin
            // Both operands stay consumed; nothing is written back.
            err_valid <= 1'b1;
            err_code  <= ERR_DIVZ;
            state     <= S_IDLE;
          end else begin
            wdat  <= alu_result;
            state <= S_WRITE;
          end
`else
          wdat  <= alu_result;
          state <= S_WRITE;
`endif
        end
        S_WRITE: begin
          // Cannot overflow after a binary op: READ_A/READ_B freed two entries.
          tail  <= tail + 1'b1;
          count <= count + 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_queue_calc_ctrl.sv
module tb_queue_calc_ctrl;

  localparam int DEPTH = 8;
  localparam int AW = $clog2(DEPTH);

  localparam logic [2:0] PUSH = 3'd0, POP = 3'd1, ADD = 3'd2, MUL = 3'd3,
                         SUB = 3'd4, DIV = 3'd5, NOP = 3'd7;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    in_opcode = 3'd7;
  logic [7:0]    in_data = 8'd0;
  logic [2:0]    alu_opcode;
  logic [15:0]   alu_operands;
  logic [7:0]    alu_result;
  logic          out_valid;
  logic [7:0]    out_data;
  logic [AW:0]   count;
  logic          busy;
  logic          err_valid;
  logic [1:0]    err_code;

  queue_calc_ctrl #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode), .in_data(in_data),
    .alu_opcode(alu_opcode), .alu_operands(alu_operands), .alu_result(alu_result),
    .out_valid(out_valid), .out_data(out_data), .count(count), .busy(busy),
    .err_valid(err_valid), .err_code(err_code)
  );

  always #5 clk = ~clk;

  // Reference ALU: 8-bit truncated arithmetic, A = operands[7:0], B = operands[15:8].
  logic [7:0]  alu_a, alu_b;
  logic [15:0] alu_prod;
  assign alu_a = alu_operands[7:0];
  assign alu_b = alu_operands[15:8];
  assign alu_prod = alu_a * alu_b;
  always_comb begin
    alu_result = 8'd0;
    case (alu_opcode)
      3'd2: alu_result = alu_a + alu_b;
      3'd3: alu_result = alu_prod[7:0];
      3'd4: alu_result = alu_a - alu_b;
      3'd5: alu_result = (alu_b == 8'd0) ? 8'hFF : alu_a / alu_b;
      3'd6: alu_result = (alu_b == 8'd0) ? alu_a : alu_a % alu_b;
      default: alu_result = 8'd0;
    endcase
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Values captured in the cycle after accept, and while waiting for IDLE.
  logic        cap_ov, cap_ev, saw_err;
  logic [7:0]  cap_od;
  logic [1:0]  cap_ec, seen_code;
  logic [2:0]  exec_op;
  logic [15:0] exec_ops;
  int          lat;

  task automatic send(input logic [2:0] op, input logic [7:0] d);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("ready_timeout", 32'd0, 32'd1);
    in_valid = 1'b1; in_opcode = op; in_data = d;
    @(negedge clk);
    in_valid = 1'b0; in_opcode = NOP;
    cap_ov = out_valid; cap_od = out_data; cap_ev = err_valid; cap_ec = err_code;
    saw_err = err_valid; seen_code = err_code;
    exec_op = NOP; exec_ops = 16'd0;
    lat = 1;
    while (!in_ready && lat < 50) begin
      if (alu_opcode != NOP) begin
        exec_op = alu_opcode;
        exec_ops = alu_operands;
      end
      @(negedge clk);
      lat++;
      if (err_valid) begin
        saw_err = 1'b1;
        seen_code = err_code;
      end
    end
    if (!in_ready) check("idle_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    // Reset state, sampled while rst is still low.
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_count", count, 0);
    check("rst_busy", busy, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_err_valid", err_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_err_code", err_code, 0);
    check("rst_alu_opcode", alu_opcode, 7);
    check("rst_alu_operands", alu_operands, 0);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_ready", in_ready, 1);

    // NOP: no effect, in_ready stays high.
    send(NOP, 8'h55);
    check("nop_lat", lat, 1);
    check("nop_count", count, 0);
    check("nop_err", cap_ev, 0);

    // PUSH 5, PUSH 3, ADD, POP -> 8.
    send(PUSH, 8'd5);
    check("push_lat", lat, 2);
    check("push_count1", count, 1);
    send(PUSH, 8'd3);
    check("push_count2", count, 2);
    send(ADD, 8'd0);
    check("add_lat", lat, 5);
    check("add_alu_op", exec_op, ADD);
    check("add_alu_ops", exec_ops, 16'h0305);
    check("add_err", saw_err, 0);
    check("add_count", count, 1);
    send(POP, 8'd0);
    check("add_pop_valid", cap_ov, 1);
    check("add_pop_data", cap_od, 8);
    check("add_pop_count", count, 0);
    check("add_pop_err", cap_ev, 0);

    // PUSH 3, PUSH 10, SUB, POP -> 3-10 wraps to F9.
    send(PUSH, 8'd3);
    send(PUSH, 8'd10);
    send(SUB, 8'd0);
    check("sub_lat", lat, 5);
    check("sub_alu_ops", exec_ops, 16'h0A03);
    send(POP, 8'd0);
    check("sub_pop_data", cap_od, 8'hF9);
    check("sub_count", count, 0);

    // Fill to DEPTH, overflow on the ninth, drain in order (pointers wrap).
    for (int i = 1; i <= DEPTH; i++) send(PUSH, 8'(i));
    check("full_count", count, DEPTH);
    send(PUSH, 8'd9);
    check("ovf_err_valid", cap_ev, 1);
    check("ovf_err_code", cap_ec, 2'b10);
    check("ovf_lat", lat, 1);
    check("ovf_count", count, DEPTH);
    for (int i = 1; i <= DEPTH; i++) begin
      send(POP, 8'd0);
      check($sformatf("drain_%0d", i), cap_od, i);
    end
    check("drain_count", count, 0);

    // Underflows: POP on empty, MUL with one entry.
    send(POP, 8'd0);
    check("pop_empty_err", cap_ev, 1);
    check("pop_empty_code", cap_ec, 2'b01);
    check("pop_empty_valid", cap_ov, 0);
    check("pop_empty_count", count, 0);
    send(PUSH, 8'd4);
    send(MUL, 8'd0);
    check("mul1_err", cap_ev, 1);
    check("mul1_code", cap_ec, 2'b01);
    check("mul1_lat", lat, 1);
    check("mul1_count", count, 1);
    send(POP, 8'd0);
    check("mul1_pop_data", cap_od, 4);

    // Divide by zero.
    send(PUSH, 8'd7);
    send(PUSH, 8'd0);
    send(DIV, 8'd0);
`ifdef QCTRL_DIVZERO_CHK_EN
    check("divz_err", saw_err, 1);
    check("divz_code", seen_code, 2'b11);
    check("divz_count", count, 0);
`else
    check("divz_err", saw_err, 0);
    check("divz_count", count, 1);
    send(POP, 8'd0);
    check("divz_pop_data", cap_od, 8'hFF);
`endif

    // Reset during EXEC aborts the op and discards the queue.
    send(PUSH, 8'd1);
    send(PUSH, 8'd2);
    @(negedge clk);
    in_valid = 1'b1; in_opcode = ADD;
    @(negedge clk);
    in_valid = 1'b0; in_opcode = NOP;
    repeat (2) @(negedge clk);
    check("exec_alu_op", alu_opcode, ADD);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_busy", busy, 0);
    check("midrst_count", count, 0);
    check("midrst_ready", in_ready, 0);
    check("midrst_alu_op", alu_opcode, 7);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_ready_after", in_ready, 1);
    send(POP, 8'd0);
    check("midrst_pop_err", cap_ec, 2'b01);
    check("midrst_pop_count", count, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
